// File: rtl/peripheral_input_conditioner.sv
// Synchronizes and debounces raw board inputs, latches sticky rise/fall events
// and exposes STATE/RISE/FALL/MASK registers on a 32-bit address/data bus.
module peripheral_input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_inputs,
  input  logic [31:0]         address,
  input  logic [31:0]         input_data,
  input  logic                should_write,
  output logic [31:0]         output_data,
  output logic [CHANNELS-1:0] conditioned_inputs,
  output logic                event_pending
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0]      r_s1;
  logic [CHANNELS-1:0]      r_s2;
  logic [CHANNELS-1:0]      r_lvl;
  logic [CHANNELS-1:0]      r_rise;
  logic [CHANNELS-1:0]      r_fall;
  logic [CHANNELS-1:0]      r_mask;
  logic [COUNTER_WIDTH-1:0] r_cnt      [CHANNELS];
  logic [COUNTER_WIDTH-1:0] w_cnt_next [CHANNELS];
  logic [CHANNELS-1:0]      w_lvl_next;
  logic [CHANNELS-1:0]      w_rise_set;
  logic [CHANNELS-1:0]      w_fall_set;
  logic [CHANNELS-1:0]      w_wdata;
  logic [1:0]               w_sel;
  logic                     w_wr_rise;
  logic                     w_wr_fall;
  logic                     w_wr_mask;
  logic                     w_unused;

  assign w_sel     = address[3:2];
  assign w_wdata   = input_data[CHANNELS-1:0];
  assign w_wr_rise = should_write && (w_sel == 2'd1);
  assign w_wr_fall = should_write && (w_sel == 2'd2);
  assign w_wr_mask = should_write && (w_sel == 2'd3);
  assign w_unused  = ^{address[31:4], address[1:0], input_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_inputs;
      r_s2 <= r_s1;
    end
  end

  // A level is accepted only after s2 has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    w_lvl_next = r_lvl;
    w_rise_set = '0;
    w_fall_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_s2[i] == r_lvl[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_cnt_next[i] = '0;
        w_lvl_next[i] = r_s2[i];
        w_rise_set[i] = r_s2[i];
        w_fall_set[i] = ~r_s2[i];
      end else begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Clears are applied before sets so a new event on the clearing edge survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
      r_lvl  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_mask <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_lvl  <= w_lvl_next;
      r_rise <= (r_rise & ~(w_wr_rise ? w_wdata : '0)) | w_rise_set;
      r_fall <= (r_fall & ~(w_wr_fall ? w_wdata : '0)) | w_fall_set;
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
    end
  end

  always_comb begin
    output_data = '0;
    case (w_sel)
      2'd0:    output_data = 32'(r_lvl);
      2'd1:    output_data = 32'(r_rise);
      2'd2:    output_data = 32'(r_fall);
      default: output_data = 32'(r_mask);
    endcase
  end

  assign conditioned_inputs = r_lvl;
  assign event_pending      = |((r_rise | r_fall) & r_mask);

endmodule

// File: tb/tb_peripheral_input_conditioner.sv
// Scoreboard bench: the driver predicts each edge with a sample-history model and
// queues the expectation; a monitor pops and compares after every posedge.
`timescale 1ns/1ps
module tb_peripheral_input_conditioner;
  localparam int CH = 4;
  localparam int DB = 4;
  localparam int CW = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  raw_inputs;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        should_write;
  logic [31:0] output_data;
  logic [3:0]  conditioned_inputs;
  logic        event_pending;

  peripheral_input_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .raw_inputs(raw_inputs),
    .address(address), .input_data(input_data), .should_write(should_write),
    .output_data(output_data), .conditioned_inputs(conditioned_inputs),
    .event_pending(event_pending)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [3:0]  cond;
    logic        ev;
    logic [31:0] rdata;
  } exp_t;

  exp_t       expQ[$];
  int         checkCount = 0;
  int         passCount  = 0;
  logic [3:0] mHist[$];
  logic [3:0] mLvl, mRise, mFall, mMask;

  // Model: a channel accepts value v when the last DB synchronized samples all equal v.
  function automatic void modelReset();
    mHist.delete();
    for (int k = 0; k < DB + 2; k++) mHist.push_back(4'h0);
    mLvl = '0; mRise = '0; mFall = '0; mMask = '0;
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, mLvl};
      2'd1:    return {28'd0, mRise};
      2'd2:    return {28'd0, mFall};
      default: return {28'd0, mMask};
    endcase
  endfunction

  function automatic exp_t modelEdge(logic [3:0] raw, logic [31:0] a, logic [31:0] d, logic wr);
    exp_t       e;
    logic [3:0] rs, fs;
    logic       v;
    bit         steady;
    int         n;
    mHist.push_back(raw);
    if (mHist.size() > 32) void'(mHist.pop_front());
    n  = mHist.size();
    rs = '0;
    fs = '0;
    for (int i = 0; i < CH; i++) begin
      v = mHist[n-3][i];
      steady = 1'b1;
      for (int k = 0; k < DB; k++) if (mHist[n-3-k][i] != v) steady = 1'b0;
      if (steady && v != mLvl[i]) begin
        mLvl[i] = v;
        if (v) rs[i] = 1'b1; else fs[i] = 1'b1;
      end
    end
    if (wr) begin
      case (a[3:2])
        2'd1:    mRise &= ~d[3:0];
        2'd2:    mFall &= ~d[3:0];
        2'd3:    mMask = d[3:0];
        default: ;
      endcase
    end
    mRise |= rs;
    mFall |= fs;
    e.cond  = mLvl;
    e.ev    = |((mRise | mFall) & mMask);
    e.rdata = modelRead(a);
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(logic [3:0] raw, logic [31:0] a, logic [31:0] d, logic wr);
    @(negedge clock);
    raw_inputs   = raw;
    address      = a;
    input_data   = d;
    should_write = wr;
    expQ.push_back(modelEdge(raw, a, d, wr));
  endtask

  task automatic waitEdge();
    @(posedge clock);
    #2;
  endtask

  task automatic runCycles(int n, logic [3:0] raw, logic [31:0] a);
    repeat (n) applyStimulus(raw, a, 32'd0, 1'b0);
  endtask

  // Pulse reset between edges, checking every output while it is held, then model the next edge.
  task automatic doReset(logic [3:0] raw);
    @(negedge clock);
    raw_inputs   = raw;
    should_write = 1'b0;
    #1 reset_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 32'(a << 2);
      #1;
      checkOutput("reset read", output_data, 32'd0);
      checkOutput("reset cond", {28'd0, conditioned_inputs}, 32'd0);
      checkOutput("reset event", {31'd0, event_pending}, 32'd0);
    end
    #1 reset_n = 1'b1;
    address = 32'h4;
    modelReset();
    expQ.push_back(modelEdge(raw, 32'h4, 32'd0, 1'b0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("mon cond", {28'd0, conditioned_inputs}, {28'd0, e.cond});
        checkOutput("mon event", {31'd0, event_pending}, {31'd0, e.ev});
        checkOutput("mon rdata", output_data, e.rdata);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [3:0]  raw;
    logic [31:0] a;
    reset_n = 1'b0; raw_inputs = '0; address = '0; input_data = '0; should_write = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    doReset(4'h0);

    // Reset recovery latency with all inputs held high
    runCycles(8, 4'hF, 32'h0);
    doReset(4'hF);
    runCycles(4, 4'hF, 32'h0);
    waitEdge();
    checkOutput("reset lvl early", {28'd0, conditioned_inputs}, 32'h0);
    applyStimulus(4'hF, 32'h4, 32'd0, 1'b0);
    waitEdge();
    checkOutput("reset lvl latency", {28'd0, conditioned_inputs}, 32'hF);
    checkOutput("reset rise flags", output_data, 32'hF);

    // Clean press on button 1
    doReset(4'h0);
    runCycles(3, 4'h0, 32'h0);
    runCycles(5, 4'h4, 32'h0);
    waitEdge();
    checkOutput("press k+4", {28'd0, conditioned_inputs}, 32'h0);
    applyStimulus(4'h4, 32'h4, 32'd0, 1'b0);
    waitEdge();
    checkOutput("press k+5", {28'd0, conditioned_inputs}, 32'h4);
    checkOutput("press rise", output_data, 32'h4);
    applyStimulus(4'h4, 32'h8, 32'd0, 1'b0);
    waitEdge();
    checkOutput("press fall", output_data, 32'h0);

    // Bounce on analog 25 never qualifies
    applyStimulus(4'h4, 32'h4, 32'h4, 1'b1);
    applyStimulus(4'h4, 32'hC, 32'hF, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(((c / 2) % 2) ? 4'h5 : 4'h4, 32'h0, 32'd0, 1'b0);
    runCycles(8, 4'h4, 32'h0);
    waitEdge();
    checkOutput("bounce level", {28'd0, conditioned_inputs}, 32'h4);
    checkOutput("bounce event", {31'd0, event_pending}, 32'h0);
    applyStimulus(4'h4, 32'h4, 32'd0, 1'b0);
    waitEdge();
    checkOutput("bounce rise", output_data, 32'h0);
    applyStimulus(4'h4, 32'h8, 32'd0, 1'b0);
    waitEdge();
    checkOutput("bounce fall", output_data, 32'h0);

    // W1C and ignored STATE write
    doReset(4'h0);
    runCycles(7, 4'h5, 32'h0);
    applyStimulus(4'h5, 32'h4, 32'd0, 1'b0);
    waitEdge();
    checkOutput("w1c before", output_data, 32'h5);
    applyStimulus(4'h5, 32'h4, 32'h1, 1'b1);
    waitEdge();
    checkOutput("w1c after", output_data, 32'h4);
    applyStimulus(4'h5, 32'h0, 32'hF, 1'b1);
    waitEdge();
    checkOutput("state write ignored", output_data, 32'h5);

    // Clear of bit 1 lands on the edge that sets it; bit 2 clear still applies
    runCycles(5, 4'h7, 32'h4);
    applyStimulus(4'h7, 32'h4, 32'h6, 1'b1);
    waitEdge();
    checkOutput("set wins", output_data, 32'h2);

    // Mask gating of event_pending
    runCycles(6, 4'hF, 32'h0);
    applyStimulus(4'hF, 32'h4, 32'hF, 1'b1);
    applyStimulus(4'hF, 32'hC, 32'h8, 1'b1);
    waitEdge();
    checkOutput("mask idle", {31'd0, event_pending}, 32'h0);
    runCycles(5, 4'h7, 32'h0);
    waitEdge();
    checkOutput("mask pre fall", {31'd0, event_pending}, 32'h0);
    applyStimulus(4'h7, 32'h0, 32'd0, 1'b0);
    waitEdge();
    checkOutput("mask fall event", {31'd0, event_pending}, 32'h1);
    applyStimulus(4'h7, 32'h8, 32'h8, 1'b1);
    waitEdge();
    checkOutput("mask cleared", {31'd0, event_pending}, 32'h0);
    runCycles(6, 4'h5, 32'h0);
    runCycles(6, 4'h7, 32'h0);
    waitEdge();
    checkOutput("masked rise", {31'd0, event_pending}, 32'h0);
    applyStimulus(4'h7, 32'h4, 32'd0, 1'b0);
    waitEdge();
    checkOutput("rise ch1 flag", output_data, 32'h2);

    // Randomized traffic against the model
    raw = 4'h7;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) == 0) begin
        doReset(raw);
      end else begin
        for (int i = 0; i < CH; i++) if ($urandom_range(5) == 0) raw[i] = ~raw[i];
        a = $urandom;
        applyStimulus(raw, a, $urandom, ($urandom_range(3) == 0));
      end
    end
    applyStimulus(raw, 32'h0, 32'd0, 1'b0);
    waitEdge();
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/peripheral_input_conditioner.md
# peripheral_input_conditioner

Input front-end for the memory-mapped peripheral block: synchronizes and debounces raw board inputs (analog ports 25/26, buttons 1/2) and drives the clean levels onto the peripheral block's `input_peripherals` bus. It latches rising and falling edge events in sticky flags that the CPU reads and clears over the same 32-bit address/data/write bus. It also raises a level `event_pending` line for any enabled event.

## Interface
- `CHANNELS`, 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, 27000: consecutive stable cycles required to accept a level change (1 ms at 27 MHz); must be ≥1.
- `COUNTER_WIDTH`, 16: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clock`  in  1  single system clock, posedge active.
- `reset_n`  in  1  asynchronous, active-low reset.
- `raw_inputs`  in  CHANNELS  asynchronous pins; bit order follows the peripheral convention (0: analog 25, 1: analog 26, 2: button 1, 3: button 2).
- `address`  in  32  byte address; only `address[3:2]` decoded.
- `input_data`  in  32  write data.
- `should_write`  in  1  write strobe, sampled on posedge.
- `output_data`  out  32  combinational read data for `address`.
- `conditioned_inputs`  out  CHANNELS  debounced levels; connects to `input_peripherals`.
- `event_pending`  out  1  OR of (rise|fall) & mask.

## Operation
- Per channel, a two-flop synchronizer: `raw` → `s1` → `s2`.
- Per channel, a debounce counter `cnt` and an accepted level `lvl`, which drives `conditioned_inputs`. On each posedge:
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`, and set `rise[i]` (0→1) or `fall[i]` (1→0).
  - Else: `cnt <= cnt+1`.
  - Any cycle where `s2` returns to `lvl` restarts the count from zero.
- Register map, selected by `address[3:2]`; bits ≥ CHANNELS read 0:
  - 0 STATE: read `conditioned_inputs`; writes ignored.
  - 1 RISE: sticky rise flags; write-1-to-clear using `input_data[CHANNELS-1:0]`.
  - 2 FALL: sticky fall flags; write-1-to-clear.
  - 3 MASK: read/write enable mask for `event_pending`.
- Writes take effect on the posedge where `should_write`=1. Other address bits are ignored.
- `event_pending` = |(( `rise` | `fall` ) & `mask`), combinational from registers.

## Timing
- Reset (`reset_n`=0) asynchronously clears `s1`, `s2`, `cnt`, `lvl`, `rise`, `fall` and `mask`. Outputs immediately: `conditioned_inputs`=0, `event_pending`=0, `output_data`=0 at every address.
- Latency: if `raw[i]` changes and stays stable before posedge k, `s2` updates at k+1 and `lvl`/flag update at posedge k+1+DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=1, `lvl` follows `s2` one cycle later, i.e. 2-cycle sync plus 1.
- `output_data` reflects a register update in the same cycle after the updating edge; no read side effects.
- Set and W1C clear of the same flag bit on the same edge: set wins and the bit stays 1.
- Clears of other bits on that edge still apply.
- Both flags can be pending simultaneously for one channel (rise then fall before a clear); each is independent.
- A reset mid-debounce discards the count. After release, inputs held high are accepted as rises after full latency, since `lvl` restarts at 0.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, CHANNELS=4.
- Reset: run with `raw_inputs`=4'b1111 until all levels are 1, then pulse `reset_n` low mid-cycle → all outputs 0 asynchronously. After release, `conditioned_inputs` reaches 4'b1111 exactly 5 edges after the first posedge, and RISE reads 0xF.
- Clean press: `raw[2]` 0→1 before edge k, held → `conditioned_inputs[2]` rises at edge k+5, not k+4. Read addr 0x4 → 0x00000004; addr 0x8 → 0.
- Bounce: `raw[0]` toggles every 2 cycles for 20 cycles, then held 0 → `conditioned_inputs[0]` stays 0, RISE/FALL stay 0, `event_pending` stays 0.
- W1C: with RISE=4'b0101, write 0x1 to addr 0x4 → RISE reads 0x4. Write 0xF to addr 0x0 → STATE unchanged.
- Simultaneous: schedule the W1C of RISE bit 1 on the same edge that sets it → RISE bit 1 reads 1 afterward.
- Mask: write MASK=4'b1000, produce fall on channel 3 → `event_pending`=1 after the flag edge. Write 0x8 to addr 0x8 → 0. A rise on channel 1 with mask bit 1 clear keeps `event_pending`=0.
